// File: rtl/tri_fetch_pkg.sv
// Shared constants, fill-state encoding and triangle record for the tri_fetch block.
package tri_fetch_pkg;

  localparam int unsigned VERT_WORDS  = 15;
  localparam int unsigned COLOR_WORDS = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FULL
  } fill_state_e;

  typedef struct packed {
    logic [VERT_WORDS-1:0][31:0] vert;
    logic [23:0]                 color1;
    logic [23:0]                 color2;
    logic [23:0]                 color3;
  } tri_rec_t;

endpackage

// File: rtl/tri_fetch_buf.sv
// tri_buf: one triangle slot, written word-by-index, with a full flag.
module tri_buf #(
  parameter int unsigned VERT_WORDS = tri_fetch_pkg::VERT_WORDS,
  parameter int unsigned IDX_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [31:0]             wr_data,
  input  logic                    set_full,
  input  logic                    clr_full,
  output logic                    full,
  output tri_fetch_pkg::tri_rec_t rec
);
  import tri_fetch_pkg::*;

  logic     full_q;
  tri_rec_t rec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else if (set_full) begin
      full_q <= 1'b1;
    end else if (clr_full) begin
      full_q <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while the slot is full.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < VERT_WORDS; i++) begin
        if (wr_idx == IDX_W'(i)) rec_q.vert[i] <= wr_data;
      end
      if (wr_idx == IDX_W'(VERT_WORDS))     rec_q.color1 <= wr_data[23:0];
      if (wr_idx == IDX_W'(VERT_WORDS + 1)) rec_q.color2 <= wr_data[23:0];
      if (wr_idx == IDX_W'(VERT_WORDS + 2)) rec_q.color3 <= wr_data[23:0];
    end
  end

  assign full = full_q;
  assign rec  = rec_q;

endmodule

// File: rtl/tri_fetch.sv
// Triangle fetch: packs a word stream into triangle records for the vertex stage.
// Define TRI_FETCH_DBLBUF_EN for ping-pong buffering (fill next while presenting current).
module tri_fetch #(
  parameter int unsigned VERT_WORDS  = tri_fetch_pkg::VERT_WORDS,
  parameter int unsigned COLOR_WORDS = tri_fetch_pkg::COLOR_WORDS,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [CNT_W-1:0]            tri_count,
  input  logic [31:0]                 in_word,
  input  logic                        in_word_valid,
  output logic                        in_word_ready,
  output logic [VERT_WORDS-1:0][31:0] vertex_out,
  output logic [23:0]                 color_out1,
  output logic [23:0]                 color_out2,
  output logic [23:0]                 color_out3,
  output logic                        out_data_valid,
  output logic                        done_out,
  input  logic                        stall_in,
  output logic                        busy,
  output logic                        frame_done
);
  import tri_fetch_pkg::*;

`ifdef TRI_FETCH_DBLBUF_EN
  localparam int unsigned NBUF = 2;
`else
  localparam int unsigned NBUF = 1;
`endif
  localparam int unsigned     TOT_WORDS = VERT_WORDS + COLOR_WORDS;
  localparam int unsigned     IDX_W     = $clog2(TOT_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOT_WORDS - 1);

  fill_state_e      state_q, state_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] to_recv_q, to_recv_d;
  logic [1:0]       occ_q, occ_d;
  logic             wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic             frame_done_q, frame_done_d;

  logic            in_fire, out_fire, tri_in, frame_start, last_out;
  logic [NBUF-1:0] full_vec;
  tri_rec_t        rec [NBUF];
  tri_rec_t        rd_rec;
  logic            rd_full;

  assign in_fire     = in_word_valid && in_word_ready;
  assign out_fire    = out_data_valid && !stall_in;
  assign tri_in      = in_fire && (word_idx_q == LAST_IDX);
  assign frame_start = (state_q == S_IDLE) && start;
  assign last_out    = out_fire && (remaining_q == CNT_W'(1));

  for (genvar i = 0; i < NBUF; i++) begin : g_buf
    tri_buf #(
      .VERT_WORDS (VERT_WORDS),
      .IDX_W      (IDX_W)
    ) u_tri_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (in_fire && (wr_sel_q == 1'(i))),
      .wr_idx   (word_idx_q),
      .wr_data  (in_word),
      .set_full (tri_in && (wr_sel_q == 1'(i))),
      .clr_full (out_fire && (rd_sel_q == 1'(i))),
      .full     (full_vec[i]),
      .rec      (rec[i])
    );
  end

  assign rd_full = (rd_sel_q && NBUF > 1) ? full_vec[NBUF-1] : full_vec[0];
  assign rd_rec  = (rd_sel_q && NBUF > 1) ? rec[NBUF-1] : rec[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx_q   <= '0;
      remaining_q  <= '0;
      to_recv_q    <= '0;
      occ_q        <= '0;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      word_idx_q   <= word_idx_d;
      remaining_q  <= remaining_d;
      to_recv_q    <= to_recv_d;
      occ_q        <= occ_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    word_idx_d  = word_idx_q;
    remaining_d = remaining_q;
    to_recv_d   = to_recv_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    if (frame_start) begin
      word_idx_d  = '0;
      remaining_d = tri_count;
      to_recv_d   = tri_count;
      wr_sel_d    = 1'b0;
      rd_sel_d    = 1'b0;
    end
    if (in_fire) word_idx_d = tri_in ? '0 : word_idx_q + 1'b1;
    if (tri_in) begin
      to_recv_d = to_recv_q - 1'b1;
      wr_sel_d  = (NBUF > 1) ? ~wr_sel_q : wr_sel_q;
    end
    if (out_fire) begin
      remaining_d = remaining_q - 1'b1;
      rd_sel_d    = (NBUF > 1) ? ~rd_sel_q : rd_sel_q;
    end
    occ_d        = occ_q + 2'(tri_in) - 2'(out_fire);
    frame_done_d = (frame_start && tri_count == '0) || last_out;
  end

  // Next state: park in S_FULL once nothing is left to receive or no slot is free.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start && tri_count != '0) state_d = S_FILL;
      S_FILL, S_FULL: begin
        if (last_out)                                      state_d = S_IDLE;
        else if (to_recv_d == '0 || occ_d == 2'(NBUF))     state_d = S_FULL;
        else                                               state_d = S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_word_ready  = (state_q == S_FILL);
    busy           = (state_q != S_IDLE);
    out_data_valid = rd_full;
    done_out       = rd_full && (remaining_q == CNT_W'(1));
    vertex_out     = rd_full ? rd_rec.vert   : '0;
    color_out1     = rd_full ? rd_rec.color1 : '0;
    color_out2     = rd_full ? rd_rec.color2 : '0;
    color_out3     = rd_full ? rd_rec.color3 : '0;
    frame_done     = frame_done_q;
  end

endmodule

// File: tb/tb_tri_fetch.sv
// Randomized self-checking bench for tri_fetch against a queue-of-triangles model.
module tb_tri_fetch;
  localparam int unsigned VW    = 15;
  localparam int unsigned CW    = 3;
  localparam int unsigned TOT   = VW + CW;
  localparam int unsigned CNT_W = 16;
`ifdef TRI_FETCH_DBLBUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [CNT_W-1:0]     tri_count = '0;
  logic [31:0]          in_word = '0;
  logic                 in_word_valid = 1'b0;
  logic                 stall_in = 1'b0;
  logic                 in_word_ready, out_data_valid, done_out, busy, frame_done;
  logic [VW-1:0][31:0]  vertex_out;
  logic [23:0]          color_out1, color_out2, color_out3;

  tri_fetch #(
    .VERT_WORDS  (VW),
    .COLOR_WORDS (CW),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .tri_count      (tri_count),
    .in_word        (in_word),
    .in_word_valid  (in_word_valid),
    .in_word_ready  (in_word_ready),
    .vertex_out     (vertex_out),
    .color_out1     (color_out1),
    .color_out2     (color_out2),
    .color_out3     (color_out3),
    .out_data_valid (out_data_valid),
    .done_out       (done_out),
    .stall_in       (stall_in),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0][31:0] vert;
    logic [23:0]         c1, c2, c3;
    bit                  last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out = 0;
  int   n_exp_total = 0;
  int   stall_mode = 0;  // 0 off, 1 held, 2 random

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (stall_mode)
      0:       stall_in = 1'b0;
      1:       stall_in = 1'b1;
      default: stall_in = 1'($urandom_range(0, 1));
    endcase
  end

  // Presented triangle must match the oldest outstanding one on every valid cycle.
  always @(negedge clk) begin
    if (rst_n && done_out && !out_data_valid) check_eq("done_without_valid", done_out, 0);
    if (rst_n && out_data_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", out_data_valid, 0);
      end else begin
        check_eq("vertex", vertex_out, exp_q[0].vert);
        check_eq("color1", color_out1, exp_q[0].c1);
        check_eq("color2", color_out2, exp_q[0].c2);
        check_eq("color3", color_out3, exp_q[0].c3);
        check_eq("done_out", done_out, exp_q[0].last);
        if (!stall_in) begin
          exp_q.delete(0);
          n_out++;
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] w, input int gap);
    int idle;
    int budget;
    idle   = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
    budget = 1000;
    in_word_valid = 1'b0;
    repeat (idle) begin
      in_word = $urandom;
      @(posedge clk);
      #1;
    end
    in_word       = w;
    in_word_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_word_ready) break;
      budget--;
      if (budget == 0) begin
        check_eq("ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_word_valid = 1'b0;
  endtask

  task automatic send_tri(input bit last, input int gap, input bit ff, input int nwords);
    logic [31:0] w [TOT];
    exp_t        e;
    for (int i = 0; i < TOT; i++) begin
      w[i] = $urandom;
      if (ff && i >= VW) w[i][31:24] = 8'hFF;
    end
    for (int i = 0; i < VW; i++) e.vert[i] = w[i];
    e.c1   = w[VW][23:0];
    e.c2   = w[VW+1][23:0];
    e.c3   = w[VW+2][23:0];
    e.last = last;
    if (nwords == TOT) begin
      exp_q.push_back(e);
      n_exp_total++;
    end
    for (int i = 0; i < nwords; i++) push_word(w[i], gap);
  endtask

  task automatic start_frame(input int n);
    @(posedge clk);
    #1;
    tri_count = CNT_W'(n);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    tri_count = CNT_W'($urandom);
  endtask

  task automatic wait_frame_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    check_eq("frame_done_seen", seen, 1);
    check_eq("busy_after_done", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, in_word_ready, 0);
    check_eq({tag, "_valid"}, out_data_valid, 0);
    check_eq({tag, "_done"}, done_out, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_frame_done"}, frame_done, 0);
    check_eq({tag, "_vertex"}, vertex_out, 0);
    check_eq({tag, "_colors"}, {color_out1, color_out2, color_out3}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [VW-1:0][31:0] snap_v;
    logic [23:0]         snap_c3;
    int                  n;

    // Reset state and no readiness before start
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("ready_before_start", in_word_ready, 0);
    end

    // Single triangle, back-to-back words, no stall
    @(posedge clk);
    #1;
    start_frame(1);
    check_eq("ready_after_start", in_word_ready, 1);
    check_eq("busy_after_start", busy, 1);
    send_tri(1'b1, 0, 1'b0, TOT);
    @(negedge clk);
    check_eq("valid_latency", out_data_valid, 1);
    check_eq("done_latency", done_out, 1);
    @(negedge clk);
    check_eq("single_frame_done", frame_done, 1);
    check_eq("single_busy_clear", busy, 0);
    check_eq("single_valid_drop", out_data_valid, 0);
    @(negedge clk);
    check_eq("frame_done_pulse", frame_done, 0);

    // Three triangles with a 10-cycle stall on the first presentation
    @(posedge clk);
    #1;
    stall_mode = 1;
    @(posedge clk);
    #1;
    fork
      begin
        start_frame(3);
        for (int k = 0; k < 3; k++) send_tri(k == 2, 0, 1'b0, TOT);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clk);
          seen = out_data_valid;
        end
        check_eq("stall_valid_seen", seen, 1);
        snap_v  = vertex_out;
        snap_c3 = color_out3;
        repeat (10) begin
          @(negedge clk);
          check_eq("stall_valid_hold", out_data_valid, 1);
          check_eq("stall_vertex_stable", vertex_out, snap_v);
          check_eq("stall_color_stable", color_out3, snap_c3);
        end
        stall_mode = 0;
      end
    join
    wait_frame_done(300);

    // Zero-triangle frame
    start_frame(0);
    check_eq("zero_busy_start", busy, 0);
    @(negedge clk);
    check_eq("zero_frame_done", frame_done, 1);
    check_eq("zero_busy", busy, 0);
    check_eq("zero_valid", out_data_valid, 0);
    @(negedge clk);
    check_eq("zero_frame_done_pulse", frame_done, 0);
    check_eq("zero_ready", in_word_ready, 0);

    // Every-other-cycle valid with 0xFF in color high bytes
    @(posedge clk);
    #1;
    start_frame(2);
    send_tri(1'b0, 1, 1'b1, TOT);
    send_tri(1'b1, 1, 1'b1, TOT);
    wait_frame_done(300);

    // Readiness while the first triangle is stalled at the output
    stall_mode = 1;
    @(posedge clk);
    #1;
    start_frame(2);
    send_tri(1'b0, 0, 1'b0, TOT);
    repeat (4) begin
      @(negedge clk);
      check_eq("ready_while_stalled", in_word_ready, DBL);
    end
    @(posedge clk);
    #1;
    if (DBL) begin
      send_tri(1'b1, 0, 1'b0, TOT);
      @(negedge clk);
      check_eq("ready_both_full", in_word_ready, 0);
      stall_mode = 0;
      @(posedge clk);
      #1;
    end else begin
      stall_mode = 0;
      send_tri(1'b1, 0, 1'b0, TOT);
    end
    wait_frame_done(300);

    // Reset in the middle of triangle 2, then a clean single-triangle frame
    start_frame(3);
    send_tri(1'b0, 0, 1'b0, TOT);
    send_tri(1'b0, 0, 1'b0, 8);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_frame(1);
    send_tri(1'b1, 0, 1'b0, TOT);
    wait_frame_done(300);
    check_eq("reset_queue_drained", exp_q.size(), 0);

    // Randomized frames with random gaps, stalls and color high bytes
    for (int f = 0; f < 6; f++) begin
      n = int'($urandom_range(1, 4));
      stall_mode = 2;
      start_frame(n);
      for (int k = 0; k < n; k++) send_tri(k == n - 1, 2, 1'($urandom_range(0, 1)), TOT);
      wait_frame_done(400);
      stall_mode = 0;
    end
    check_eq("final_queue_drained", exp_q.size(), 0);
    check_eq("triangles_presented", n_out, n_exp_total);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
